fpu_divsqrt_iter: RTL and testbench
===================================

# fpu_divsqrt_iter

Iterative, parametrised IEEE-754 divide / square-root unit for the RV32IMF floating-point datapath. It replaces the single-cycle combinational divider with a radix-2 digit-recurrence engine behind a valid/ready handshake. It produces correctly rounded (round-to-nearest-even) results and RISC-V exception flags. The core stalls on `in_ready` / `out_valid` while the unit works.

## Interface
- `EXP_W`, default 8: exponent field width.
- `MAN_W`, default 23: stored mantissa (fraction) width. Derived width `W = 1+EXP_W+MAN_W`, which is 32 by default.
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst_n`  in  1  reset. Asynchronous, active-low.
- `flush`  in  1  synchronous abort of any operation in progress.
- `in_valid`  in  1  operands and `op` are valid.
- `in_ready`  out  1  unit can accept. Combinational: `state==IDLE`.
- `op`  in  1  0 = divide `rs1/rs2`; 1 = square root of `rs1` (`rs2` ignored).
- `rs1`, `rs2`  in  W  operands.
- `out_valid`  out  1  result valid. Held until accepted.
- `out_ready`  in  1  consumer accepts the result.
- `fpu_result`  out  W  result.
- `fflags`  out  5  flags `{NV,DZ,OF,UF,NX}`.

## Operation
- States: IDLE, PREP, ITER, ROUND, DONE.
- IDLE→PREP on `in_valid && in_ready`. Operands and `op` are registered.
- PREP unpacks the operands and detects special cases.
  - Special case: load the result and flags, then go to DONE.
  - Otherwise: load the remainder, divisor/radicand and exponent, clear the counter, then go to ITER.
- ITER produces one quotient/root bit per cycle, MAN_W+3 cycles in total (hidden bit + MAN_W + normalisation bit + guard). Then go to ROUND.
- ROUND performs normalisation, RNE rounding (guard bit, sticky = lower bits | remainder≠0), exponent overflow/underflow handling and packing. Then go to DONE.
- DONE holds `out_valid=1`. On `out_ready`, go to IDLE.
- `flush` in any state forces IDLE on the next edge and clears `out_valid`. `flush` has priority over `in_valid`: nothing is accepted in a flush cycle.
- FTZ: an input with exponent 0 is treated as a signed zero. A result whose biased exponent is ≤0 after rounding becomes a signed zero with UF|NX.
- Overflow (biased exponent ≥ all-ones) gives a signed infinity with OF|NX.
- NX is set whenever guard or sticky is nonzero.
- Canonical NaN is `{0, all-ones exponent, 1, zeros}`, which is 0x7FC00000 by default. Every NaN result is canonical.
- Divide special cases. Sign = s1^s2.
  - Any NaN operand: canonical NaN. NV only if a NaN is signalling.
  - 0/0 or inf/inf: canonical NaN, NV.
  - Finite nonzero / 0: signed inf, DZ.
  - inf / finite: signed inf.
  - finite / inf, or 0 / nonzero: signed zero.
- Sqrt special cases:
  - NaN: canonical NaN. NV if signalling.
  - ±0: ±0.
  - +inf: +inf.
  - Any negative nonzero, including −inf: canonical NaN, NV.
- Sqrt normal path: unbiased exponent made even by shifting the radicand (radicand in [1,4)), result exponent = e/2.

## Timing
- Reset values: state IDLE, `out_valid=0`, `fpu_result=0`, `fflags=0`, counter 0. `in_ready=1` during and after reset.
- Latency, counted as edges from the accepting edge to the edge that raises `out_valid`:
  - Normal operands: MAN_W+5, which is 28 by default. This is 1 PREP + MAN_W+3 ITER + 1 ROUND.
  - Special cases: 1.
- `fpu_result` and `fflags` change only on the edge entering DONE. They stay stable while `out_valid && !out_ready`.
- After the output handshake edge, `in_ready=1` in the following cycle. There is no same-cycle output→input bypass, so a new operation is accepted one cycle after the handshake at the earliest.
- `in_valid` while busy is ignored. The upstream holds its request.
- Reset asserted mid-operation returns the unit to the reset values immediately, with no partial result.
- `op`/`rs1`/`rs2` are sampled only on the accepting edge. Later changes have no effect.

## Test plan
- Exact divide: `rs1=0x40C00000`, `rs2=0x40000000`, op=0 → `0x40400000`, fflags 0, `out_valid` exactly 28 edges after accept.
- Inexact divide and overflow:
  - 0x3F800000/0x40400000 → `0x3EAAAAAB`, fflags `00001`.
  - 0x7F7FFFFF/0x3F000000 → `0x7F800000`, fflags `00101`.
- Square root:
  - sqrt(0x40800000) → `0x40000000`, fflags 0.
  - sqrt(0x40000000) → `0x3FB504F3`, fflags `00001`.
  - sqrt(0xBF800000) → `0x7FC00000`, fflags `10000`, latency 1.
- Specials:
  - 0x3F800000/0x00000000 → `0x7F800000`, fflags `01000`, latency 1.
  - 0/0 → `0x7FC00000`, `10000`.
  - Subnormal `0x00000001` / 1.0 → `0x00000000`.
- Backpressure: hold `out_ready=0` for 10 cycles after `out_valid`. Result and flags stay stable and `in_ready=0`. Pulse `out_ready` and check `in_ready=1` the next cycle. A back-to-back second divide is correct.
- Abort:
  - Assert `flush` at ITER cycle 10 → IDLE next edge, `out_valid` never rises. The following 6.0/2.0 gives `0x40400000`.
  - Repeat with `rst_n` low mid-ITER → all outputs return to their reset values.

Source files
------------

// File: rtl/fpu_divsqrt_iter.sv
// ---------------------------------------------------------------------------
// fpu_divsqrt_iter
// Iterative IEEE-754 divide / square-root unit. It uses a radix-2
// restoring digit recurrence with one result bit per cycle and rounds to
// nearest-even. Subnormal inputs and results are flushed to zero.
//
// States
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | waiting for an operation, in_ready=1
//   S_PREP  | unpack registered operands, resolve special cases
//   S_ITER  | one quotient/root bit per cycle, MAN_W+3 cycles
//   S_ROUND | normalise, round to nearest-even, range check, pack
//   S_DONE  | out_valid=1, result held until out_ready
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                synchronous abort; forces S_IDLE on the next edge
//   in_valid / in_ready  operand handshake (in_ready = state is S_IDLE)
//   op                   0 = rs1/rs2, 1 = sqrt(rs1)
//   rs1, rs2             operands, sampled only on the accepting edge
//   out_valid/out_ready  result handshake
//   fpu_result, fflags   result and {NV,DZ,OF,UF,NX}
// ---------------------------------------------------------------------------
module fpu_divsqrt_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         op,
    input  logic [W-1:0] rs1,
    input  logic [W-1:0] rs2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] fpu_result,
    output logic [4:0]   fflags
);

    localparam int NB = MAN_W + 3;          // result bits produced
    localparam int RW = MAN_W + 6;          // partial remainder width
    localparam int EW = EXP_W + 3;          // signed working exponent width
    localparam int CW = $clog2(NB + 1);
    localparam logic signed [EW-1:0] BIAS_S = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX_S = EW'((1 << EXP_W) - 1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_ROUND, S_DONE} state_t;

    state_t state_q, state_d;

    logic                 op_q;
    logic [W-1:0]         a_q, b_q;
    logic                 sign_q;
    logic signed [EW-1:0] exp_q;
    logic [RW-1:0]        rem_q;
    logic [MAN_W:0]       dvs_q;
    logic [2*NB-1:0]      rad_q;
    logic [NB-1:0]        quo_q;
    logic [CW-1:0]        cnt_q;
    logic [W-1:0]         res_q;
    logic [4:0]           flg_q;

    logic accept;

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign fpu_result = res_q;
    assign fflags     = flg_q;
    assign accept     = in_ready && in_valid && !flush;

    // ---------------- operand unpack ----------------
    logic               a_sgn, b_sgn;
    logic [EXP_W-1:0]   a_exp, b_exp;
    logic [MAN_W-1:0]   a_man, b_man;
    logic               a_zero, a_inf, a_nan, a_snan;
    logic               b_zero, b_inf, b_nan, b_snan;

    assign {a_sgn, a_exp, a_man} = a_q;
    assign {b_sgn, b_exp, b_man} = b_q;

    // exponent 0 is treated as zero regardless of fraction (flush-to-zero)
    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign a_inf  = (&a_exp) && (a_man == '0);
    assign b_inf  = (&b_exp) && (b_man == '0);
    assign a_nan  = (&a_exp) && (a_man != '0);
    assign b_nan  = (&b_exp) && (b_man != '0);
    assign a_snan = a_nan && !a_man[MAN_W-1];
    assign b_snan = b_nan && !b_man[MAN_W-1];

    // ---------------- special-case decode ----------------
    logic         spec_hit;
    logic [W-1:0] spec_res;
    logic [4:0]   spec_flg;
    logic         div_sgn;

    assign div_sgn = a_sgn ^ b_sgn;

    always_comb begin
        spec_hit = 1'b0;
        spec_res = '0;
        spec_flg = '0;
        if (!op_q) begin
            if (a_nan || b_nan) begin
                spec_hit    = 1'b1;
                spec_res    = QNAN;
                spec_flg[4] = a_snan || b_snan;
            end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
                spec_hit    = 1'b1;
                spec_res    = QNAN;
                spec_flg[4] = 1'b1;
            end else if (a_inf) begin
                spec_hit = 1'b1;
                spec_res = {div_sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else if (b_zero) begin
                spec_hit    = 1'b1;
                spec_res    = {div_sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                spec_flg[3] = 1'b1;
            end else if (b_inf || a_zero) begin
                spec_hit = 1'b1;
                spec_res = {div_sgn, {(W-1){1'b0}}};
            end
        end else begin
            if (a_nan) begin
                spec_hit    = 1'b1;
                spec_res    = QNAN;
                spec_flg[4] = a_snan;
            end else if (a_zero) begin
                spec_hit = 1'b1;
                spec_res = {a_sgn, {(W-1){1'b0}}};
            end else if (a_sgn) begin
                spec_hit    = 1'b1;
                spec_res    = QNAN;
                spec_flg[4] = 1'b1;
            end else if (a_inf) begin
                spec_hit = 1'b1;
                spec_res = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end
        end
    end

    // ---------------- normal-path setup ----------------
    logic [MAN_W:0]       ma, mb;
    logic signed [EW-1:0] e1, e2, u, u_even, prep_exp;
    logic [MAN_W+1:0]     mx;
    logic [RW-1:0]        prep_rem;
    logic [2*NB-1:0]      prep_rad;

    assign ma = {1'b1, a_man};
    assign mb = {1'b1, b_man};
    assign e1 = {3'b000, a_exp};
    assign e2 = {3'b000, b_exp};

    always_comb begin
        // sqrt: make the unbiased exponent even by folding an odd bit into
        // the radicand, so the radicand lies in [1,4) and the root in [1,2)
        u        = e1 - BIAS_S;
        u_even   = {u[EW-1:1], 1'b0};
        mx       = u[0] ? {ma, 1'b0} : {1'b0, ma};
        prep_rad = {mx, {(MAN_W+4){1'b0}}};
        prep_exp = '0;
        prep_rem = '0;
        if (op_q) begin
            prep_exp = (u_even >>> 1) + BIAS_S;
        end else begin
            prep_exp = e1 - e2 + BIAS_S;
            prep_rem = {{(RW-MAN_W-1){1'b0}}, ma};
        end
    end

    // ---------------- recurrence step ----------------
    logic [RW-1:0] d_ext, d_sub, s_sh, s_trial, iter_rem;
    logic          d_ge, s_ge, iter_bit;

    always_comb begin
        d_ext   = {{(RW-MAN_W-1){1'b0}}, dvs_q};
        d_ge    = (rem_q >= d_ext);
        d_sub   = d_ge ? (rem_q - d_ext) : rem_q;
        // sqrt: bring down the next two radicand bits, trial = 4*root + 1
        s_sh    = {rem_q[RW-3:0], rad_q[2*NB-1 -: 2]};
        s_trial = {1'b0, quo_q, 2'b01};
        s_ge    = (s_sh >= s_trial);
        if (op_q) begin
            iter_rem = s_ge ? (s_sh - s_trial) : s_sh;
            iter_bit = s_ge;
        end else begin
            iter_rem = d_sub << 1;
            iter_bit = d_ge;
        end
    end

    // ---------------- normalise / round / pack ----------------
    logic                 norm, grd, stk, rup, carry, inexact;
    logic [MAN_W:0]       mant, mant_r;
    logic signed [EW-1:0] exp_n, exp_f;
    logic [W-1:0]         rnd_res;
    logic [4:0]           rnd_flg;

    always_comb begin
        // quotient MSB has weight 1; if it is clear the result is in
        // [0.5,1) and everything shifts up by one place
        norm    = quo_q[NB-1];
        mant    = norm ? quo_q[NB-1:2] : quo_q[NB-2:1];
        grd     = norm ? quo_q[1] : quo_q[0];
        stk     = (norm && quo_q[0]) || (rem_q != '0);
        exp_n   = exp_q - {{(EW-1){1'b0}}, !norm};
        rup     = grd && (stk || mant[0]);
        // an all-ones mantissa wraps to zero on round-up; the lost hidden
        // bit signals the carry into the exponent
        mant_r  = mant + {{MAN_W{1'b0}}, rup};
        carry   = !mant_r[MAN_W];
        exp_f   = exp_n + {{(EW-1){1'b0}}, carry};
        inexact = grd || stk;
        rnd_res = {sign_q, exp_f[EXP_W-1:0], mant_r[MAN_W-1:0]};
        rnd_flg = {4'b0000, inexact};
        if (exp_f >= EMAX_S) begin
            rnd_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            rnd_flg = 5'b00101;
        end else if (exp_f <= $signed({EW{1'b0}})) begin
            rnd_res = {sign_q, {(W-1){1'b0}}};
            rnd_flg = 5'b00011;
        end
    end

    // ---------------- state machine ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (in_valid) state_d = S_PREP;
                S_PREP:  state_d = spec_hit ? S_DONE : S_ITER;
                S_ITER:  if (cnt_q == CW'(NB - 1)) state_d = S_ROUND;
                S_ROUND: state_d = S_DONE;
                S_DONE:  if (out_ready) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            sign_q <= 1'b0;
            exp_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            rad_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            res_q  <= '0;
            flg_q  <= '0;
        end else begin
            if (accept) begin
                op_q <= op;
                a_q  <= rs1;
                b_q  <= rs2;
            end
            if (!flush) begin
                case (state_q)
                    S_PREP: begin
                        if (spec_hit) begin
                            res_q <= spec_res;
                            flg_q <= spec_flg;
                        end else begin
                            sign_q <= op_q ? 1'b0 : div_sgn;
                            exp_q  <= prep_exp;
                            rem_q  <= prep_rem;
                            dvs_q  <= mb;
                            rad_q  <= prep_rad;
                            quo_q  <= '0;
                            cnt_q  <= '0;
                        end
                    end
                    S_ITER: begin
                        rem_q <= iter_rem;
                        quo_q <= {quo_q[NB-2:0], iter_bit};
                        rad_q <= {rad_q[2*NB-3:0], 2'b00};
                        cnt_q <= cnt_q + 1'b1;
                    end
                    S_ROUND: begin
                        res_q <= rnd_res;
                        flg_q <= rnd_flg;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fpu_divsqrt_iter.sv
module tb_fpu_divsqrt_iter;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        op;
    logic [31:0] rs1, rs2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] fpu_result;
    logic [4:0]  fflags;

    int n_chk  = 0;
    int n_pass = 0;

    fpu_divsqrt_iter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .rs1        (rs1),
        .rs2        (rs2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fpu_result (fpu_result),
        .fflags     (fflags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b);
        chk("accept_ready", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        op       = o;
        rs1      = a;
        rs2      = b;
        tick();
        in_valid = 1'b0;
        op       = ~o;
        rs1      = $urandom;
        rs2      = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic ack(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_in_ready_after_ack"}, {31'b0, in_ready}, 32'd1);
        chk({tag, "_out_valid_after_ack"}, {31'b0, out_valid}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res,
                          input logic [4:0] fl, input int lat_exp);
        int lat;
        issue(o, a, b);
        wait_done(lat);
        chk({tag, "_lat"}, 32'(lat), 32'(lat_exp));
        chk({tag, "_res"}, fpu_result, res);
        chk({tag, "_flags"}, {27'b0, fflags}, {27'b0, fl});
        ack(tag);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},  {31'b0, in_ready},  32'd1);
        chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_result"},    fpu_result,         32'd0);
        chk({tag, "_flags"},     {27'b0, fflags},    32'd0);
    endtask

    initial begin
        int lat;
        int bad;
        int seen;

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        op        = 1'b0;
        rs1       = '0;
        rs2       = '0;
        out_ready = 1'b0;
        #12;
        chk_reset_vals("reset");
        rst_n = 1'b1;
        tick();
        chk_reset_vals("post_reset");

        // divide
        run_op("div_6_2",    1'b0, 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 28);
        run_op("div_1_3",    1'b0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 28);
        run_op("div_ovf",    1'b0, 32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 5'b00101, 28);
        run_op("div_unf",    1'b0, 32'h00800000, 32'h40000000, 32'h00000000, 5'b00011, 28);
        // square root
        run_op("sqrt_4",     1'b1, 32'h40800000, 32'h12345678, 32'h40000000, 5'b00000, 28);
        run_op("sqrt_2",     1'b1, 32'h40000000, 32'h00000000, 32'h3FB504F3, 5'b00001, 28);
        run_op("sqrt_neg1",  1'b1, 32'hBF800000, 32'h00000000, 32'h7FC00000, 5'b10000, 1);
        run_op("sqrt_negz",  1'b1, 32'h80000000, 32'h00000000, 32'h80000000, 5'b00000, 1);
        run_op("sqrt_inf",   1'b1, 32'h7F800000, 32'h00000000, 32'h7F800000, 5'b00000, 1);
        // specials
        run_op("div_by_0",   1'b0, 32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 1);
        run_op("div_0_0",    1'b0, 32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 1);
        run_op("div_sub",    1'b0, 32'h00000001, 32'h3F800000, 32'h00000000, 5'b00000, 1);
        run_op("div_snan",   1'b0, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'b10000, 1);

        // backpressure and back-to-back
        issue(1'b0, 32'h40C00000, 32'h40000000);
        wait_done(lat);
        chk("bp_lat", 32'(lat), 32'd28);
        bad = 0;
        repeat (10) begin
            tick();
            if (fpu_result !== 32'h40400000 || fflags !== 5'b0 || in_ready !== 1'b0 || out_valid !== 1'b1)
                bad++;
        end
        chk("bp_stable", 32'(bad), 32'd0);
        chk("bp_res", fpu_result, 32'h40400000);
        ack("bp");
        run_op("b2b_1_3", 1'b0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 28);

        // flush in idle has priority over in_valid
        flush    = 1'b1;
        in_valid = 1'b1;
        rs1      = 32'h3F800000;
        rs2      = 32'h00000000;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_idle_not_accepted", {31'b0, in_ready}, 32'd1);

        // flush during ITER cycle 10
        issue(1'b0, 32'h40C00000, 32'h40000000);
        repeat (11) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        seen = 0;
        repeat (40) begin
            tick();
            if (out_valid) seen = 1;
        end
        chk("flush_no_result", 32'(seen), 32'd0);
        run_op("after_flush", 1'b0, 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 28);

        // reset during ITER
        issue(1'b0, 32'h3F800000, 32'h40400000);
        repeat (12) tick();
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mid_reset");
        #2;
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            tick();
            if (out_valid) seen = 1;
        end
        chk("reset_no_result", 32'(seen), 32'd0);
        run_op("after_reset", 1'b0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 28);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
